lr_shift_sequencer: RTL and testbench
=====================================

// Module: lr_shift_sequencer
// PURPOSE
// - Upstream command stage for the 8-bit L/R shift register: accepts one shift command per
//   valid/ready handshake, then drives the shifter's In/L/R/Si controls cycle by cycle.
// - Keeps a shadow copy of the shifter contents. Returns the final word with a one-cycle
//   Done pulse.
// - Sits between the control logic (command issuer) and the shift-register datapath.
// PARAMETERS
// - WIDTH  8  data width; must equal the shifter width
// - CNT_W  4  width of Cmd_count; must satisfy 2**CNT_W > WIDTH
// PORTS
// - Clk        in   1        single clock; all state changes on the rising edge
// - Rst_n      in   1        reset: asynchronous, active-low
// - Cmd_valid  in   1        command present
// - Cmd_ready  out  1        sequencer can accept a command (IDLE only)
// - Cmd_dir    in   1        0 = shift left, 1 = shift right
// - Cmd_rot    in   1        1 = rotate (Si = bit shifted out); 0 = fill with Cmd_si
// - Cmd_si     in   1        serial fill bit when Cmd_rot = 0
// - Cmd_count  in   CNT_W    number of shift cycles, 0..WIDTH (larger values are clamped to WIDTH)
// - Cmd_data   in   WIDTH    word loaded before shifting
// - In         out  WIDTH    parallel load value to the shifter
// - L          out  1        shift-left control to the shifter
// - R          out  1        shift-right control to the shifter
// - Si         out  1        serial input to the shifter
// - Out_data   out  WIDTH    shadow register; holds the final word from Done onward
// - Busy       out  1        high in LOAD and SHIFT
// - Done       out  1        single-cycle pulse marking command completion
// BEHAVIOUR
// - Shifter control encoding:
//   - L=0,R=0: load In.
//   - L=0,R=1: right shift, {Si, q[W-1:1]}.
//   - L=1,R=0: left shift, {q[W-2:0], Si}.
//   - L=1,R=1: never driven by this block.
// - Reset, asynchronous on Rst_n low, at any time including mid-command:
//   - State goes to IDLE and the remaining count to 0.
//   - In, L, R, Si, Out_data, Busy and Done all go to 0. Cmd_ready=1 after release.
//   - Any partially executed command is discarded and no Done is issued.
// - FSM has four states: IDLE, LOAD, SHIFT, DONE.
//   - IDLE:
//     - Outputs: Cmd_ready=1, L=R=0, In holds the last value.
//     - Transition: Cmd_valid & Cmd_ready latches the dir, rot, si, data and clamped count fields, then -> LOAD.
//   - LOAD (1 cycle):
//     - Outputs: In=data, L=R=0, Out_data<=data.
//     - Transition: -> SHIFT if count>0, else -> DONE.
//   - SHIFT (count cycles):
//     - Outputs: R=dir, L=~dir.
//     - Si = rot ? (dir ? Out_data[0] : Out_data[W-1]) : si.
//     - Out_data shifts the same way as the shifter. The remaining count decrements each cycle.
//     - Transition: -> DONE in the cycle the remaining count reaches 1.
//   - DONE (1 cycle):
//     - Outputs: Done=1, L=R=0, In=Out_data. In=Out_data means the shifter reload leaves its contents unchanged.
//     - Transition: -> IDLE.
// - Timing:
//   - Latency from the accept edge to the Done cycle is count+2 cycles.
//   - Back-to-back throughput is one command per count+3 cycles.
// - Cmd_valid is ignored while Cmd_ready=0.
// - Command fields are sampled only at accept. Changes to them mid-command have no effect.
// - The clamp is count_eff = (Cmd_count > WIDTH) ? WIDTH : Cmd_count.
// - Out_data is stable from DONE until the next LOAD.
// STRUCTURE
// - Shared header lr_shift_defs.vh contains:
//   - State codes S_IDLE=2'd0, S_LOAD=2'd1, S_SHIFT=2'd2, S_DONE=2'd3.
//   - Control codes LR_LOAD=2'b00, LR_RIGHT=2'b01, LR_LEFT=2'b10.
//   - The shifter and the bench include it as well.
// - One sub-module, lr_shift_shadow, handles the shadow register:
//   - Parallel load, left/right shift with Si, and async clear.
//   - The sequencer holds the FSM, the command latch, the down-counter and the Si/rotate mux.
// TESTING
// - Bench instantiates the sequencer driving the 8-bit shifter.
// - Every cycle, the bench checks the shifter Out against Out_data.
// - Scenarios:
//   - Reset: Rst_n=0 for 3 cycles -> Out_data=00, L=R=Si=0, Done=0, Busy=0; Cmd_ready=1 after release.
//   - Right fill: data=8'hFF, dir=1, rot=0, si=0, count=3 -> Done 5 cycles after accept, Out_data=8'h1F.
//   - Left rotate: data=8'b10000001, dir=0, rot=1, count=1 -> Out_data=8'b00000011; a full 8-step rotate returns 8'h81.
//   - Clamp / zero count:
//     - count=15, data=8'hAA, dir=0, si=1 -> exactly 8 shifts, Out_data=8'hFF.
//     - count=0 -> Done 2 cycles after accept, Out_data=data.
//   - Handshake: Cmd_valid held high continuously for two commands:
//     - Cmd_ready low during LOAD/SHIFT/DONE.
//     - Second command accepted only in IDLE.
//     - Second command's fields are not sampled early.
//   - Mid-command reset: assert Rst_n=0 during SHIFT cycle 2 of a count=6 command:
//     - Immediate return to IDLE values, no Done.
//     - A following command executes correctly.

Source files
------------

// File: rtl/lr_shift_sequencer_pkg.sv
// Shared widths, FSM state codes and shifter control codes for the L/R shift sequencer.
package lr_shift_sequencer_pkg;

    localparam int unsigned LR_WIDTH = 8;
    localparam int unsigned LR_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // {L, R} encodings understood by the shifter; 2'b11 is never driven
    localparam logic [1:0] LR_LOAD  = 2'b00;
    localparam logic [1:0] LR_RIGHT = 2'b01;
    localparam logic [1:0] LR_LEFT  = 2'b10;

endpackage

// File: rtl/lr_shift_shadow.sv
// Shadow copy of the external shifter: same load/left/right behaviour, fed by the same controls.
module lr_shift_shadow
    import lr_shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = LR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_val,
    input  logic             l,
    input  logic             r,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_nxt_c
);

    logic [1:0] lr;

    assign lr = {l, r};

    // Next contents, exposed so the sequencer can pick the rotate bit one cycle ahead
    always_comb begin
        q_nxt_c = q;
        case (lr)
            LR_LOAD:  q_nxt_c = load_val;
            LR_RIGHT: q_nxt_c = {si, q[WIDTH-1:1]};
            LR_LEFT:  q_nxt_c = {q[WIDTH-2:0], si};
            default:  q_nxt_c = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nxt_c;
        end
    end

endmodule

// File: rtl/lr_shift_sequencer.sv
// Command stage for the L/R shift register: accepts a shift command, drives In/L/R/Si
// cycle by cycle and tracks the shifter contents in a shadow register.
module lr_shift_sequencer
    import lr_shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = LR_WIDTH,
    parameter int unsigned CNT_W = LR_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Cmd_valid,
    output logic             Cmd_ready,
    input  logic             Cmd_dir,
    input  logic             Cmd_rot,
    input  logic             Cmd_si,
    input  logic [CNT_W-1:0] Cmd_count,
    input  logic [WIDTH-1:0] Cmd_data,
    output logic [WIDTH-1:0] In,
    output logic             L,
    output logic             R,
    output logic             Si,
    output logic [WIDTH-1:0] Out_data,
    output logic             Busy,
    output logic             Done
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               rot_q, rot_d;
    logic               fill_q, fill_d;

    logic [WIDTH-1:0]   in_d;
    logic               l_d, r_d, si_d;
    logic               busy_d, done_d, ready_d;

    logic [CNT_W-1:0]   count_eff;
    logic [WIDTH-1:0]   shadow_nxt;
    logic               shift_si;

    assign count_eff = (Cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : Cmd_count;

    // Si for the upcoming shift cycle, taken from the word the shifter will hold then
    assign shift_si = rot_q ? (dir_q ? shadow_nxt[0] : shadow_nxt[WIDTH-1]) : fill_q;

    lr_shift_shadow #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .load_val (In),
        .l        (L),
        .r        (R),
        .si       (Si),
        .q        (Out_data),
        .q_nxt_c  (shadow_nxt)
    );

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        fill_d  = fill_q;
        in_d    = In;
        l_d     = 1'b0;
        r_d     = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (Cmd_valid && Cmd_ready) begin
                    state_d = S_LOAD;
                    dir_d   = Cmd_dir;
                    rot_d   = Cmd_rot;
                    fill_d  = Cmd_si;
                    rem_d   = count_eff;
                    in_d    = Cmd_data;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (rem_q != '0) begin
                    state_d = S_SHIFT;
                    busy_d  = 1'b1;
                    l_d     = ~dir_q;
                    r_d     = dir_q;
                    si_d    = shift_si;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    in_d    = shadow_nxt;
                end
            end
            S_SHIFT: begin
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    rem_d   = '0;
                    done_d  = 1'b1;
                    // Reloading the final word leaves the shifter unchanged
                    in_d    = shadow_nxt;
                end else begin
                    rem_d   = rem_q - CNT_W'(1);
                    busy_d  = 1'b1;
                    l_d     = ~dir_q;
                    r_d     = dir_q;
                    si_d    = shift_si;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            rot_q     <= 1'b0;
            fill_q    <= 1'b0;
            In        <= '0;
            L         <= 1'b0;
            R         <= 1'b0;
            Si        <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Cmd_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            rot_q     <= rot_d;
            fill_q    <= fill_d;
            In        <= in_d;
            L         <= l_d;
            R         <= r_d;
            Si        <= si_d;
            Busy      <= busy_d;
            Done      <= done_d;
            Cmd_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_lr_shift_sequencer.sv
// Bench: sequencer driving a behavioural 8-bit L/R shifter, table vectors, corner sequences
// and random commands against a loop-based reference model.
module tb_lr_shift_sequencer;
    import lr_shift_sequencer_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          Cmd_valid, Cmd_ready, Cmd_dir, Cmd_rot, Cmd_si;
    logic [CW-1:0] Cmd_count;
    logic [W-1:0]  Cmd_data, In, Out_data;
    logic          L, R, Si, Busy, Done;
    logic [W-1:0]  shifter_q;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    lr_shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clk(clk), .Rst_n(rst_n), .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready),
        .Cmd_dir(Cmd_dir), .Cmd_rot(Cmd_rot), .Cmd_si(Cmd_si), .Cmd_count(Cmd_count),
        .Cmd_data(Cmd_data), .In(In), .L(L), .R(R), .Si(Si), .Out_data(Out_data),
        .Busy(Busy), .Done(Done)
    );

    // The 8-bit shifter being driven
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shifter_q <= '0;
        else begin
            case ({L, R})
                LR_LOAD:  shifter_q <= In;
                LR_RIGHT: shifter_q <= {Si, shifter_q[W-1:1]};
                LR_LEFT:  shifter_q <= {shifter_q[W-2:0], Si};
                default:  shifter_q <= 'x;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("shifter_vs_shadow", 32'(shifter_q), 32'(Out_data));
            check("lr_exclusive", 32'(L & R), 32'd0);
        end
    end

    // Reference: apply the clamped number of single-bit shifts to the word
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic dir,
                                               input logic rot, input logic si,
                                               input logic [CW-1:0] cnt);
        int n;
        logic [W-1:0] w;
        logic b;
        n = (int'(cnt) > int'(W)) ? int'(W) : int'(cnt);
        w = d;
        for (int i = 0; i < n; i++) begin
            if (dir) begin
                b = rot ? w[0] : si;
                w = {b, w[W-1:1]};
            end else begin
                b = rot ? w[W-1] : si;
                w = {w[W-2:0], b};
            end
        end
        return w;
    endfunction

    function automatic int ref_lat(input logic [CW-1:0] cnt);
        return ((int'(cnt) > int'(W)) ? int'(W) : int'(cnt)) + 2;
    endfunction

    task automatic drive_fields(input logic dir, input logic rot, input logic si,
                                input logic [CW-1:0] cnt, input logic [W-1:0] data);
        Cmd_dir = dir; Cmd_rot = rot; Cmd_si = si; Cmd_count = cnt; Cmd_data = data;
    endtask

    // Issue one command; latency counts cycles from the accept cycle to the Done cycle
    task automatic run_cmd(input string name, input logic dir, input logic rot, input logic si,
                           input logic [CW-1:0] cnt, input logic [W-1:0] data,
                           input logic [W-1:0] exp_data, input int exp_lat);
        int lat;
        int guard;
        @(negedge clk);
        Cmd_valid = 1'b1;
        drive_fields(dir, rot, si, cnt, data);
        guard = 0;
        while (!Cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_ready"}, 32'(Cmd_ready), 32'd1);
        @(negedge clk);
        Cmd_valid = 1'b0;
        drive_fields(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     CW'($urandom_range(0, 15)), W'($urandom));
        lat = 1;
        while (!Done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_data"}, 32'(Out_data), 32'(exp_data));
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(Done), 32'd0);
        check({name, "_hold"}, 32'(Out_data), 32'(exp_data));
        check({name, "_idle_ready"}, 32'(Cmd_ready), 32'd1);
    endtask

    typedef struct packed {
        logic          dir;
        logic          rot;
        logic          si;
        logic [CW-1:0] cnt;
        logic [W-1:0]  data;
        logic [W-1:0]  exp;
        logic [7:0]    lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n, busy_n, lat, done_n;
        logic [W-1:0] res_a;
        logic dir, rot, si;
        logic [CW-1:0] cnt;
        logic [W-1:0] data;

        vecs[0] = '{dir: 1'b1, rot: 1'b0, si: 1'b0, cnt: 4'd3,  data: 8'hFF, exp: 8'h1F, lat: 8'd5};
        vecs[1] = '{dir: 1'b0, rot: 1'b1, si: 1'b0, cnt: 4'd1,  data: 8'h81, exp: 8'h03, lat: 8'd3};
        vecs[2] = '{dir: 1'b0, rot: 1'b1, si: 1'b0, cnt: 4'd8,  data: 8'h81, exp: 8'h81, lat: 8'd10};
        vecs[3] = '{dir: 1'b0, rot: 1'b0, si: 1'b1, cnt: 4'd15, data: 8'hAA, exp: 8'hFF, lat: 8'd10};
        vecs[4] = '{dir: 1'b1, rot: 1'b1, si: 1'b1, cnt: 4'd0,  data: 8'h5A, exp: 8'h5A, lat: 8'd2};
        vecs[5] = '{dir: 1'b1, rot: 1'b1, si: 1'b0, cnt: 4'd1,  data: 8'h01, exp: 8'h80, lat: 8'd3};
        vecs[6] = '{dir: 1'b0, rot: 1'b0, si: 1'b0, cnt: 4'd4,  data: 8'hF0, exp: 8'h00, lat: 8'd6};
        vecs[7] = '{dir: 1'b1, rot: 1'b0, si: 1'b1, cnt: 4'd9,  data: 8'h00, exp: 8'hFF, lat: 8'd10};

        Cmd_valid = 1'b0;
        drive_fields(1'b0, 1'b0, 1'b0, '0, '0);

        // Reset held for three cycles
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_data", 32'(Out_data), 32'd0);
        check("rst_lrsi", 32'({L, R, Si}), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(Cmd_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].dir, vecs[i].rot, vecs[i].si,
                    vecs[i].cnt, vecs[i].data, vecs[i].exp, int'(vecs[i].lat));
        end

        // Cmd_valid held high across two commands; the second's fields appear early
        @(negedge clk);
        Cmd_valid = 1'b1;
        drive_fields(1'b1, 1'b0, 1'b1, 4'd2, 8'h0F);
        check("hs_a_ready", 32'(Cmd_ready), 32'd1);
        @(negedge clk);
        drive_fields(1'b0, 1'b1, 1'b0, 4'd3, 8'h3C);
        n = 0; busy_n = 0; res_a = '0;
        while (!Cmd_ready && n < 20) begin
            if (Busy) busy_n++;
            if (Done) res_a = Out_data;
            n++;
            @(negedge clk);
        end
        check("hs_ready_low_cycles", 32'(n), 32'd4);
        check("hs_busy_cycles", 32'(busy_n), 32'd3);
        check("hs_a_data", 32'(res_a), 32'h0000_00C3);
        @(negedge clk);
        Cmd_valid = 1'b0;
        lat = 1;
        while (!Done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("hs_b_latency", 32'(lat), 32'd5);
        check("hs_b_data", 32'(Out_data), 32'h0000_00E1);

        // Reset during the second shift cycle of a count=6 command
        @(negedge clk);
        @(negedge clk);
        Cmd_valid = 1'b1;
        drive_fields(1'b0, 1'b1, 1'b0, 4'd6, 8'h96);
        check("mid_accept_ready", 32'(Cmd_ready), 32'd1);
        @(negedge clk);
        Cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy_before", 32'(Busy), 32'd1);
        check("mid_left_before", 32'(L), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_data", 32'(Out_data), 32'd0);
        check("mid_rst_in", 32'(In), 32'd0);
        check("mid_rst_lrsi", 32'({L, R, Si}), 32'd0);
        check("mid_rst_busy_done", 32'({Busy, Done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_n = 0;
        repeat (12) begin
            @(negedge clk);
            if (Done) done_n++;
        end
        check("mid_no_done", 32'(done_n), 32'd0);
        check("mid_ready", 32'(Cmd_ready), 32'd1);
        run_cmd("after_reset", 1'b0, 1'b1, 1'b0, 4'd1, 8'h81, 8'h03, 3);

        // Random commands against the reference model
        for (int i = 0; i < 150; i++) begin
            dir  = 1'($urandom_range(0, 1));
            rot  = 1'($urandom_range(0, 1));
            si   = 1'($urandom_range(0, 1));
            cnt  = CW'($urandom_range(0, 15));
            data = W'($urandom);
            run_cmd($sformatf("rand%0d", i), dir, rot, si, cnt, data,
                    ref_shift(data, dir, rot, si, cnt), ref_lat(cnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
